// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: main decoder of the pipelined core.
// Decodes the primary opcode into the datapath control bundle and registers
// it, so the bundle reaches EX one cycle after the opcode is presented.
// There is no valid/ready handshake. Each rising edge either resets, flushes
// (loads the NOP bundle), stalls (holds the bundle) or loads a fresh decode,
// in that priority order.
module pipe_ctrl_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       flush,
    input  logic [5:0] opcode,
    output logic       Jump,
    output logic       Jal,
    output logic       Branch,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegSrc,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       PCSrc,
    output logic       ALUSrc,
    output logic [4:0] AluOp
);

    // ALU operation codes
    localparam logic [4:0] ALU_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_ADD   = 5'b00001;
    localparam logic [4:0] ALU_ADDU  = 5'b00010;
    localparam logic [4:0] ALU_AND   = 5'b00011;
    localparam logic [4:0] ALU_OR    = 5'b00100;
    localparam logic [4:0] ALU_XOR   = 5'b00101;
    localparam logic [4:0] ALU_LUI   = 5'b00110;
    localparam logic [4:0] ALU_SLT   = 5'b00111;
    localparam logic [4:0] ALU_SLTU  = 5'b01000;
    localparam logic [4:0] ALU_SUBEQ = 5'b01001;
    localparam logic [4:0] ALU_SUBNE = 5'b01010;
    localparam logic [4:0] ALU_NOP   = 5'b11111;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_JALR  = 6'b000111;

    // Next-bundle signals from the combinational decode
    logic       dJump;
    logic       dJal;
    logic       dBranch;
    logic       dMemRead;
    logic       dMemWrite;
    logic       dMemtoReg;
    logic       dRegSrc;
    logic       dRegDst;
    logic       dRegWrite;
    logic       dPCSrc;
    logic       dALUSrc;
    logic [4:0] dAluOp;

    // Decode the opcode; anything unrecognised falls through to the NOP bundle
    always_comb begin
        dJump     = 1'b0;
        dJal      = 1'b0;
        dBranch   = 1'b0;
        dMemRead  = 1'b0;
        dMemWrite = 1'b0;
        dMemtoReg = 1'b0;
        dRegSrc   = 1'b0;
        dRegDst   = 1'b0;
        dRegWrite = 1'b0;
        dPCSrc    = 1'b0;
        dALUSrc   = 1'b0;
        dAluOp    = ALU_NOP;
        case (opcode)
            OP_RTYPE: begin
                dRegDst   = 1'b1;
                dRegWrite = 1'b1;
                dAluOp    = ALU_RTYPE;
            end
            OP_LB, OP_LH, OP_LW, OP_LWU, OP_LBU, OP_LHU: begin
                dMemRead  = 1'b1;
                dMemtoReg = 1'b1;
                dALUSrc   = 1'b1;
                dRegWrite = 1'b1;
                dAluOp    = ALU_ADD;
            end
            OP_SB, OP_SH, OP_SW: begin
                dMemWrite = 1'b1;
                dALUSrc   = 1'b1;
                dAluOp    = ALU_ADD;
            end
            OP_ADDI: begin
                dALUSrc   = 1'b1;
                dRegWrite = 1'b1;
                dAluOp    = ALU_ADD;
            end
            OP_ADDIU: begin
                dALUSrc   = 1'b1;
                dRegWrite = 1'b1;
                dAluOp    = ALU_ADDU;
            end
            OP_ANDI: begin
                dALUSrc   = 1'b1;
                dRegWrite = 1'b1;
                dRegSrc   = 1'b1;
                dAluOp    = ALU_AND;
            end
            OP_ORI: begin
                dALUSrc   = 1'b1;
                dRegWrite = 1'b1;
                dRegSrc   = 1'b1;
                dAluOp    = ALU_OR;
            end
            OP_XORI: begin
                dALUSrc   = 1'b1;
                dRegWrite = 1'b1;
                dRegSrc   = 1'b1;
                dAluOp    = ALU_XOR;
            end
            OP_LUI: begin
                dALUSrc   = 1'b1;
                dRegWrite = 1'b1;
                dAluOp    = ALU_LUI;
            end
            OP_SLTI: begin
                dALUSrc   = 1'b1;
                dRegWrite = 1'b1;
                dAluOp    = ALU_SLT;
            end
            OP_SLTIU: begin
                dALUSrc   = 1'b1;
                dRegWrite = 1'b1;
                dAluOp    = ALU_SLTU;
            end
            OP_BEQ: begin
                dBranch = 1'b1;
                dAluOp  = ALU_SUBEQ;
            end
            OP_BNE: begin
                dBranch = 1'b1;
                dAluOp  = ALU_SUBNE;
            end
            OP_J: begin
                dJump = 1'b1;
            end
            OP_JAL: begin
                dJump     = 1'b1;
                dJal      = 1'b1;
                dRegWrite = 1'b1;
            end
            OP_JALR: begin
                dJump     = 1'b1;
                dJal      = 1'b1;
                dPCSrc    = 1'b1;
                dRegWrite = 1'b1;
            end
            default: begin
                dAluOp = ALU_NOP;
            end
        endcase
    end

    // Bundle register: reset and flush load NOP, stall holds, else load decode
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            Jump     <= 1'b0;
            Jal      <= 1'b0;
            Branch   <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            MemtoReg <= 1'b0;
            RegSrc   <= 1'b0;
            RegDst   <= 1'b0;
            RegWrite <= 1'b0;
            PCSrc    <= 1'b0;
            ALUSrc   <= 1'b0;
            AluOp    <= ALU_NOP;
        end else if (!stall) begin
            Jump     <= dJump;
            Jal      <= dJal;
            Branch   <= dBranch;
            MemRead  <= dMemRead;
            MemWrite <= dMemWrite;
            MemtoReg <= dMemtoReg;
            RegSrc   <= dRegSrc;
            RegDst   <= dRegDst;
            RegWrite <= dRegWrite;
            PCSrc    <= dPCSrc;
            ALUSrc   <= dALUSrc;
            AluOp    <= dAluOp;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: a driver issues (rst_n, stall, flush, opcode)
// per cycle and pushes the bundle a reference model expects after the next
// edge; a monitor pops and compares at each falling edge and checks the
// bundle invariants.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       Jump, Jal, Branch, MemRead, MemWrite, MemtoReg;
    logic       RegSrc, RegDst, RegWrite, PCSrc, ALUSrc;
    logic [4:0] AluOp;

    // Bundle packing: {Jump,Jal,Branch,MemRead,MemWrite,MemtoReg,RegSrc,RegDst,RegWrite,PCSrc,ALUSrc,AluOp}
    localparam int W = 16;
    localparam logic [W-1:0] NOP_BUNDLE = 16'h001F;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] modelReg;
    int total = 0;
    int bad = 0;

    pipe_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .opcode(opcode),
        .Jump(Jump), .Jal(Jal), .Branch(Branch), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegSrc(RegSrc),
        .RegDst(RegDst), .RegWrite(RegWrite), .PCSrc(PCSrc),
        .ALUSrc(ALUSrc), .AluOp(AluOp)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference decode written from the instruction classes
    function automatic logic [W-1:0] refBundle(input logic [5:0] op);
        logic isR, isLoad, isStore, isLogicI, isArithI, isBr, isJ, isJal, isJalr;
        logic [4:0] alu;
        isR      = (op == 6'd0);
        isLoad   = op inside {6'd32, 6'd33, 6'd35, 6'd39, 6'd36, 6'd37};
        isStore  = op inside {6'd40, 6'd41, 6'd43};
        isLogicI = op inside {6'd12, 6'd13, 6'd14};
        isArithI = op inside {6'd8, 6'd9, 6'd15, 6'd10, 6'd11};
        isBr     = op inside {6'd4, 6'd5};
        isJ      = (op == 6'd2);
        isJal    = (op == 6'd3);
        isJalr   = (op == 6'd7);
        if (!(isR || isLoad || isStore || isLogicI || isArithI || isBr || isJ || isJal || isJalr))
            return NOP_BUNDLE;
        case (op)
            6'd0:  alu = 5'd0;
            6'd9:  alu = 5'd2;
            6'd12: alu = 5'd3;
            6'd13: alu = 5'd4;
            6'd14: alu = 5'd5;
            6'd15: alu = 5'd6;
            6'd10: alu = 5'd7;
            6'd11: alu = 5'd8;
            6'd4:  alu = 5'd9;
            6'd5:  alu = 5'd10;
            6'd2, 6'd3, 6'd7: alu = 5'd31;
            default: alu = 5'd1;   // loads, stores, ADDI
        endcase
        return {isJ | isJal | isJalr, isJal | isJalr, isBr, isLoad, isStore, isLoad,
                isLogicI, isR, isR | isLoad | isLogicI | isArithI | isJal | isJalr,
                isJalr, isLoad | isStore | isLogicI | isArithI, alu};
    endfunction

    // Driver: apply one cycle of inputs and queue the expected bundle
    task automatic drive(input logic r, input logic s, input logic f, input logic [5:0] op);
        @(negedge clk);
        #1;
        rst_n  = r;
        stall  = s;
        flush  = f;
        opcode = op;
        if (!r || f)
            modelReg = NOP_BUNDLE;
        else if (!s)
            modelReg = refBundle(op);
        exp_q.push_back(modelReg);
        // After the edge, wiggle the opcode: the registered bundle must not follow
        @(posedge clk);
        #2;
        opcode = 6'($urandom_range(0, 63));
    endtask

    // Monitor: compare the bundle and the invariants after each edge with a pending expectation
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        act = {Jump, Jal, Branch, MemRead, MemWrite, MemtoReg, RegSrc, RegDst,
               RegWrite, PCSrc, ALUSrc, AluOp};
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL bundle at %0t: got %h expected %h", $time, act, exp);
            end
            total++;
            if (MemRead && MemWrite) begin
                bad++;
                $display("FAIL inv_mem at %0t: MemRead=%b MemWrite=%b expected not both 1", $time, MemRead, MemWrite);
            end
            total++;
            if (MemWrite && RegWrite) begin
                bad++;
                $display("FAIL inv_store at %0t: MemWrite=%b RegWrite=%b expected RegWrite 0", $time, MemWrite, RegWrite);
            end
            total++;
            if (Branch && Jump) begin
                bad++;
                $display("FAIL inv_brj at %0t: Branch=%b Jump=%b expected not both 1", $time, Branch, Jump);
            end
            total++;
            if (PCSrc && !Jump) begin
                bad++;
                $display("FAIL inv_pcsrc at %0t: PCSrc=%b Jump=%b expected Jump 1", $time, PCSrc, Jump);
            end
        end
    end

    logic [5:0] sweep [24] = '{6'o00, 6'o40, 6'o41, 6'o43, 6'o47, 6'o44, 6'o45, 6'o50,
                               6'o51, 6'o53, 6'o10, 6'o11, 6'o14, 6'o15, 6'o16, 6'o17,
                               6'o12, 6'o13, 6'o04, 6'o05, 6'o02, 6'o03, 6'o07, 6'o24};

    // Stimulus sequence and final report
    initial begin
        modelReg = NOP_BUNDLE;
        // Reset held for two edges with LW on the bus, then release
        drive(1'b0, 1'b0, 1'b0, 6'b100011);
        drive(1'b0, 1'b0, 1'b0, 6'b100011);
        drive(1'b1, 1'b0, 1'b0, 6'b100011);
        // Decode sweep
        for (int i = 0; i < 24; i++) drive(1'b1, 1'b0, 1'b0, sweep[i]);
        // Jumps
        drive(1'b1, 1'b0, 1'b0, 6'b000011);
        drive(1'b1, 1'b0, 1'b0, 6'b000111);
        drive(1'b1, 1'b0, 1'b0, 6'b000010);
        // Stall holds SW, then flush overrides stall
        drive(1'b1, 1'b0, 1'b0, 6'b101011);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 6'b000000);
        drive(1'b1, 1'b1, 1'b1, 6'b000000);
        drive(1'b1, 1'b0, 1'b0, 6'b001101);
        // Illegal opcodes
        drive(1'b1, 1'b0, 1'b0, 6'b010100);
        drive(1'b1, 1'b0, 1'b0, 6'b111111);
        drive(1'b1, 1'b0, 1'b0, 6'b011000);
        // Mid-stream reset discards the pending decode
        drive(1'b1, 1'b0, 1'b0, 6'b001000);
        drive(1'b0, 1'b0, 1'b0, 6'b000100);
        drive(1'b1, 1'b0, 1'b0, 6'b000101);
        // Every opcode once, then a random mix of controls
        for (int i = 0; i < 64; i++) drive(1'b1, 1'b0, 1'b0, 6'(i));
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), 6'($urandom_range(0, 63)));
        end
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Main decoder of the pipelined MIPS-style core. Sits between the IF/ID register and the execute stage. Decodes the 6-bit primary opcode into the datapath control bundle and registers the result, so the bundle arrives at EX one cycle after the opcode is presented. Supports pipeline stall (hold) and flush (bubble insertion).

## Interface
- No parameters.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, synchronous, active-low.
- `stall`  in  1  When 1, hold the registered bundle.
- `flush`  in  1  When 1, load the NOP bundle.
- `opcode`  in  6  Instruction bits [31:26].
- `Jump`  out  1  Take an unconditional jump.
- `Jal`  out  1  Link: write PC+8 to the link register.
- `Branch`  out  1  Conditional branch.
- `MemRead`  out  1  Data-memory read.
- `MemWrite`  out  1  Data-memory write.
- `MemtoReg`  out  1  Write-back data comes from memory.
- `RegSrc`  out  1  Immediate is zero-extended (1) or sign-extended (0).
- `RegDst`  out  1  Destination register is rd (1) or rt (0).
- `RegWrite`  out  1  Register-file write.
- `PCSrc`  out  1  Jump target comes from register rs (1) or from the instr_index field (0).
- `ALUSrc`  out  1  ALU operand B is the immediate (1) or rt (0).
- `AluOp`  out  5  ALU operation code.

## Operation
- AluOp codes:
  - 00000 = R-type, use the funct field.
  - 00001 = ADD, 00010 = ADDU, 00011 = AND, 00100 = OR, 00101 = XOR.
  - 00110 = LUI, 00111 = SLT, 01000 = SLTU.
  - 01001 = SUB/equal test, 01010 = SUB/not-equal test.
  - 11111 = NOP.
- NOP bundle: every 1-bit output is 0 and AluOp = 11111.
- Decode table. Any signal not listed is 0.
  - 000000 R-type: RegDst, RegWrite; AluOp 00000.
  - Loads 100000 LB, 100001 LH, 100011 LW, 100111 LWU, 100100 LBU, 100101 LHU: MemRead, MemtoReg, ALUSrc, RegWrite; AluOp 00001.
  - Stores 101000 SB, 101001 SH, 101011 SW: MemWrite, ALUSrc; AluOp 00001.
  - 001000 ADDI: ALUSrc, RegWrite; AluOp 00001.
  - 001001 ADDIU: ALUSrc, RegWrite; AluOp 00010.
  - 001100 ANDI, 001101 ORI, 001110 XORI: ALUSrc, RegWrite, RegSrc; AluOp 00011 / 00100 / 00101 respectively.
  - 001111 LUI: ALUSrc, RegWrite; AluOp 00110.
  - 001010 SLTI: ALUSrc, RegWrite; AluOp 00111.
  - 001011 SLTIU: ALUSrc, RegWrite; AluOp 01000.
  - 000100 BEQ: Branch; AluOp 01001.
  - 000101 BNE: Branch; AluOp 01010.
  - 000010 J: Jump; AluOp 11111.
  - 000011 JAL: Jump, Jal, RegWrite; AluOp 11111.
  - 000111 JALR: Jump, Jal, PCSrc, RegWrite; AluOp 11111.
  - All other opcodes, including 010100: NOP bundle. No trap is raised.
- Invariants, checked by the bench on every cycle:
  - MemRead and MemWrite are never both 1.
  - MemWrite = 1 implies RegWrite = 0.
  - Branch and Jump are never both 1.
  - PCSrc = 1 implies Jump = 1.
- Decode logic is purely combinational from `opcode`. All outputs are driven directly from registers.

## Timing
- Latency is one cycle. The bundle for the opcode sampled at rising edge N is visible after edge N and holds until edge N+1.
- Priority at each edge: `rst_n`=0 first, then `flush`=1, then `stall`=1, then normal load.
  - `rst_n`=0: load the NOP bundle. This is the reset value of every output (all 1-bit outputs 0, AluOp 11111).
  - `flush`=1: load the NOP bundle. Flush overrides stall.
  - `stall`=1: outputs hold their previous values and the opcode is ignored.
  - Otherwise: load the decoded bundle for the current opcode.
- Asserting reset mid-stream discards the pending decode. The first valid bundle appears one cycle after `rst_n` returns to 1.
- An opcode change without a clock edge produces no output change.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with opcode=100011 -> all 1-bit outputs 0, AluOp=11111. Release; after the next edge -> MemRead=MemtoReg=ALUSrc=RegWrite=1, AluOp=00001.
- Sweep: drive the 24-opcode sequence 000000, 100000, 100001, 100011, 100111, 100100, 100101, 101000, 101001, 101011, 001000, 001001, 001100, 001101, 001110, 001111, 001010, 001011, 000100, 000101, 000010, 000011, 000111, 010100, one per cycle -> each bundle matches the decode table one cycle later. For example, 001101 -> ALUSrc=RegWrite=RegSrc=1, AluOp=00100.
- Jumps: opcode 000011 -> Jump=Jal=RegWrite=1, PCSrc=0. Opcode 000111 -> additionally PCSrc=1. Opcode 000010 -> Jump=1 only.
- Stall/flush: load 101011 (MemWrite=1), then assert `stall` for 3 cycles with opcode=000000 -> bundle stays the SW bundle. Then assert `flush` and `stall` together -> NOP bundle.
- Illegal opcodes: drive 010100, 111111, 011000 -> NOP bundle each cycle. Assert the invariants over a random sweep of all 64 opcodes.
